dec_divider: RTL and testbench
==============================

DEC_DIVIDER -- requirements
Module: dec_divider

Interface
REQ-001 Parameter: DW, default 8, operand byte width; dividend is 2*DW bits wide and divisor is DW bits wide.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 din_a  input  DW  dividend high byte.
REQ-005 din_b  input  DW  dividend low byte; dividend = {din_a, din_b}.
REQ-006 din_c  input  DW  divisor.
REQ-007 din_vld  input  1  operand triple valid.
REQ-008 din_rdy  output  1  block can accept operands.
REQ-009 dout_q  output  2*DW  quotient.
REQ-010 dout_r  output  DW  remainder.
REQ-011 dout_err  output  1  divide-by-zero flag, qualified by dout_vld.
REQ-012 dout_vld  output  1  result valid, one-cycle pulse.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 IDLE: din_rdy=1; transfer occurs on an edge with din_vld=1 and din_rdy=1; all other edges leave the state unchanged.
REQ-015 Transfer with din_c!=0: the block SHALL latch dividend and divisor, clear the partial remainder, load the iteration counter with 2*DW, and enter CALC.
REQ-016 CALC: the block SHALL perform one restoring shift-subtract step per cycle, MSB of dividend first, using a DW+1-bit partial remainder; after 2*DW steps it SHALL enter DONE.
REQ-017 Transfer with din_c==0: the block SHALL skip CALC, enter DONE on the next edge, and produce dout_q=all ones, dout_r=0, dout_err=1.
REQ-018 DONE: dout_vld=1 for exactly one cycle, din_rdy=0, then unconditional return to IDLE.
REQ-019 Latency (transfer edge E0, DW=8): dout_vld SHALL be high during the cycle after edge E0+17 (E0+1 for zero divisor); din_rdy SHALL be high again after edge E0+18 (E0+2).
REQ-020 din_rdy SHALL be 0 in CALC and DONE; din_vld and operand inputs SHALL be ignored there, and no operand queuing is provided.
REQ-021 dout_q, dout_r and dout_err SHALL update only on entry to DONE and hold until the next result; dout_err SHALL be 0 for nonzero divisors.
REQ-022 The result SHALL satisfy dividend = dout_q*din_c + dout_r with dout_r < din_c for every nonzero divisor, including dividend 0 and dividend all ones.
REQ-023 Back-to-back operation: a din_vld held high SHALL be accepted at the first edge on which din_rdy=1, with no extra idle cycle.

Reset
REQ-024 While rstn=0: state=IDLE, din_rdy=1, dout_q=0, dout_r=0, dout_err=0, dout_vld=0, counter and datapath registers=0.
REQ-025 Reset asserted in CALC or DONE SHALL abort the operation immediately, with no dout_vld for the aborted operands.
REQ-026 The first transfer SHALL be possible on the first rising edge after rstn deasserts.

Structure
REQ-027 FSM state encoding (IDLE, CALC, DONE) and the zero-divisor result constants SHALL live in shared package dec_pkg, alongside the constants used by dec_multip.
REQ-028 One sub-module, dec_div_step, SHALL hold the combinational single shift-subtract step (partial remainder in, next remainder and quotient bit out); the FSM, counter and registers stay in dec_divider.

Verification
REQ-029 {a,b,c}={0,0,1} -> dout_q=0, dout_r=0, dout_err=0, dout_vld 17 edges after transfer.
REQ-030 {255,255,255} -> dout_q=257, dout_r=0; {255,255,1} -> dout_q=16'hFFFF, dout_r=0.
REQ-031 {0x26,0x49,99} (9801) -> dout_q=99, dout_r=0; {0x03,0xE8,7} (1000) -> dout_q=142, dout_r=6.
REQ-032 {0,99,0} -> dout_err=1, dout_q=16'hFFFF, dout_r=0, dout_vld one edge after transfer, din_rdy back after two.
REQ-033 din_vld held high with new operands during CALC -> ignored; next transfer exactly at din_rdy=1; results match per-operation in order.
REQ-034 rstn pulsed low mid-CALC -> all outputs at reset values, no dout_vld; the next operation after reset completes correctly.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the decimal arithmetic blocks (dec_divider, dec_multip).
// Holds FSM encodings and fixed result constants.
package dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   // Divide-by-zero result: quotient saturates to all ones, remainder is zero.
   localparam logic ZDIV_Q_BIT = 1'b1;
   localparam logic ZDIV_R_BIT = 1'b0;
   localparam logic ZDIV_ERR   = 1'b1;

   // Constants for dec_multip
   localparam int MUL_DW_DEFAULT = 8;
   localparam int MUL_STAGES     = 2;

endpackage

// File: rtl/dec_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module dec_div_step #(
   parameter int DW = 8
) (
   input  logic [DW:0]   rem_in,
   input  logic          bit_in,
   input  logic [DW-1:0] divisor,
   output logic [DW:0]   rem_out,
   output logic          q_bit
);

   logic [DW+1:0] shifted;

   always_comb begin
      shifted = {rem_in, bit_in};
      q_bit   = (shifted >= {2'b00, divisor});
      // Remainder after the step is always below the divisor, so DW+1 bits suffice.
      rem_out = (DW+1)'(shifted - (q_bit ? {2'b00, divisor} : '0));
   end

endmodule

// File: rtl/dec_divider.sv
// Sequential restoring divider: {din_a,din_b} / din_c, one quotient bit per cycle,
// with a divide-by-zero shortcut that reports a saturated quotient.
module dec_divider
   import dec_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [DW-1:0]   din_a,
   input  logic [DW-1:0]   din_b,
   input  logic [DW-1:0]   din_c,
   input  logic            din_vld,
   output logic            din_rdy,
   output logic [2*DW-1:0] dout_q,
   output logic [DW-1:0]   dout_r,
   output logic            dout_err,
   output logic            dout_vld
);

   localparam int              CNT_W = $clog2(2*DW+1);
   localparam logic [CNT_W-1:0] STEPS = CNT_W'(2*DW);

   div_state_t      state_reg;
   logic [2*DW-1:0] work_reg;
   logic [DW:0]     rem_reg;
   logic [DW-1:0]   divisor_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic            zero_reg;
   logic [2*DW-1:0] q_reg;
   logic [DW-1:0]   r_reg;
   logic            err_reg;
   logic            vld_reg;
   logic            rdy_reg;

   logic [DW:0]     step_rem;
   logic            step_q;

   dec_div_step #(.DW(DW)) u_step (
      .rem_in  (rem_reg),
      .bit_in  (work_reg[2*DW-1]),
      .divisor (divisor_reg),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // work_reg shifts the dividend out of its MSB while quotient bits fill in at the LSB.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= ST_IDLE;
         work_reg    <= '0;
         rem_reg     <= '0;
         divisor_reg <= '0;
         cnt_reg     <= '0;
         zero_reg    <= 1'b0;
         q_reg       <= '0;
         r_reg       <= '0;
         err_reg     <= 1'b0;
         vld_reg     <= 1'b0;
         rdy_reg     <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               vld_reg <= 1'b0;
               if (din_vld && rdy_reg) begin
                  work_reg    <= {din_a, din_b};
                  divisor_reg <= din_c;
                  rem_reg     <= '0;
                  zero_reg    <= (din_c == '0);
                  // A zero divisor runs no steps; CALC then exits on the very next edge.
                  cnt_reg     <= (din_c == '0) ? '0 : STEPS;
                  rdy_reg     <= 1'b0;
                  state_reg   <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (cnt_reg != '0) begin
                  rem_reg  <= step_rem;
                  work_reg <= {work_reg[2*DW-2:0], step_q};
                  cnt_reg  <= cnt_reg - 1'b1;
               end else begin
                  state_reg <= ST_DONE;
                  vld_reg   <= 1'b1;
                  err_reg   <= zero_reg ? ZDIV_ERR : 1'b0;
                  q_reg     <= zero_reg ? {(2*DW){ZDIV_Q_BIT}} : work_reg;
                  r_reg     <= zero_reg ? {DW{ZDIV_R_BIT}} : rem_reg[DW-1:0];
               end
            end
            ST_DONE: begin
               vld_reg   <= 1'b0;
               rdy_reg   <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: begin
               vld_reg   <= 1'b0;
               rdy_reg   <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign din_rdy  = rdy_reg;
   assign dout_q   = q_reg;
   assign dout_r   = r_reg;
   assign dout_err = err_reg;
   assign dout_vld = vld_reg;

endmodule

// File: tb/tb_dec_divider.sv
// Self-checking bench for dec_divider: vector table, random operands, back-to-back
// and mid-operation reset sequences, with a scoreboard checking every result.
module tb_dec_divider;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [15:0] q;
      logic [7:0]  r;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic [7:0]  din_a;
   logic [7:0]  din_b;
   logic [7:0]  din_c;
   logic        din_vld;
   logic        din_rdy;
   logic [15:0] dout_q;
   logic [7:0]  dout_r;
   logic        dout_err;
   logic        dout_vld;

   int   errors;
   int   checks;
   exp_t sb[$];
   logic vld_prev;
   vec_t vecs[10];

   dec_divider #(.DW(8)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .din_a    (din_a),
      .din_b    (din_b),
      .din_c    (din_c),
      .din_vld  (din_vld),
      .din_rdy  (din_rdy),
      .dout_q   (dout_q),
      .dout_r   (dout_r),
      .dout_err (dout_err),
      .dout_vld (dout_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every dout_vld pulse pops and checks one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         vld_prev = 1'b0;
      end else begin
         if (dout_vld) begin
            chk("vld_pulse_width", vld_prev, 0);
            if (sb.size() == 0) begin
               chk("unexpected_vld", dout_vld, 0);
            end else begin
               e = sb.pop_front();
               chk("dout_q", dout_q, e.q);
               chk("dout_r", dout_r, e.r);
               chk("dout_err", dout_err, e.err);
               $display("txn: q=%0d r=%0d err=%0d (expected q=%0d r=%0d err=%0d)",
                        dout_q, dout_r, dout_err, e.q, e.r, e.err);
            end
         end
         vld_prev = dout_vld;
      end
   end

   // Drives one operation from a negedge, measures latency and din_rdy recovery.
   task automatic run_op(input vec_t v);
      int   n;
      exp_t e;
      n = 0;
      while (!din_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rdy_before_op", din_rdy, 1);
      din_a   = v.a;
      din_b   = v.b;
      din_c   = v.c;
      din_vld = 1'b1;
      @(posedge clk);
      e.q   = v.q;
      e.r   = v.r;
      e.err = v.err;
      sb.push_back(e);
      @(negedge clk);
      din_vld = 1'b0;
      din_a   = ~v.a;
      din_c   = ~v.c;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!dout_vld && n < 40);
      chk("latency", n, v.lat);
      chk("rdy_in_done", din_rdy, 0);
      @(negedge clk);
      chk("rdy_back", din_rdy, 1);
      chk("q_hold", dout_q, v.q);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        v;
      vec_t        va;
      vec_t        vb;
      exp_t        e;
      logic [15:0] dividend;
      int          n;

      errors = 0;
      checks = 0;
      vecs[0] = '{8'h00, 8'h00, 8'd1,   16'd0,     8'd0,  1'b0, 17};
      vecs[1] = '{8'hFF, 8'hFF, 8'd255, 16'd257,   8'd0,  1'b0, 17};
      vecs[2] = '{8'hFF, 8'hFF, 8'd1,   16'hFFFF,  8'd0,  1'b0, 17};
      vecs[3] = '{8'h26, 8'h49, 8'd99,  16'd99,    8'd0,  1'b0, 17};
      vecs[4] = '{8'h03, 8'hE8, 8'd7,   16'd142,   8'd6,  1'b0, 17};
      vecs[5] = '{8'h00, 8'd99, 8'd0,   16'hFFFF,  8'd0,  1'b1, 1};
      vecs[6] = '{8'h00, 8'd5,  8'd10,  16'd0,     8'd5,  1'b0, 17};
      vecs[7] = '{8'hFF, 8'hFF, 8'd2,   16'h7FFF,  8'd1,  1'b0, 17};
      vecs[8] = '{8'h12, 8'h34, 8'h56,  16'd54,    8'd16, 1'b0, 17};
      vecs[9] = '{8'h00, 8'h00, 8'd0,   16'hFFFF,  8'd0,  1'b1, 1};

      rstn    = 1'b0;
      din_a   = '0;
      din_b   = '0;
      din_c   = '0;
      din_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rdy", din_rdy, 1);
      chk("rst_q", dout_q, 0);
      chk("rst_r", dout_r, 0);
      chk("rst_err", dout_err, 0);
      chk("rst_vld", dout_vld, 0);

      // First transfer lands on the first rising edge after reset release.
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) run_op(vecs[i]);

      for (int i = 0; i < 6; i++) begin
         v.a = 8'($urandom_range(0, 255));
         v.b = 8'($urandom_range(0, 255));
         v.c = 8'($urandom_range(1, 255));
         dividend = {v.a, v.b};
         v.q   = dividend / {8'h00, v.c};
         v.r   = 8'(dividend % {8'h00, v.c});
         v.err = 1'b0;
         v.lat = 17;
         run_op(v);
      end

      // Back-to-back: din_vld stays high, operands change mid-CALC and must be ignored.
      va = vecs[3];
      vb = vecs[8];
      din_a   = va.a;
      din_b   = va.b;
      din_c   = va.c;
      din_vld = 1'b1;
      @(posedge clk);
      e.q = va.q; e.r = va.r; e.err = va.err;
      sb.push_back(e);
      @(negedge clk);
      din_a = vb.a;
      din_b = vb.b;
      din_c = vb.c;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!din_rdy && n < 40);
      chk("b2b_rdy_edges", n, 18);
      @(posedge clk);
      e.q = vb.q; e.r = vb.r; e.err = vb.err;
      sb.push_back(e);
      @(negedge clk);
      din_vld = 1'b0;
      chk("b2b_accepted", din_rdy, 0);
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_drain", sb.size(), 0);
      @(negedge clk);

      // Reset in the middle of CALC aborts the operation without a result.
      din_a   = 8'h03;
      din_b   = 8'hE8;
      din_c   = 8'd7;
      din_vld = 1'b1;
      @(posedge clk);
      e.q = 16'd142; e.r = 8'd6; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      din_vld = 1'b0;
      repeat (6) @(negedge clk);
      rstn = 1'b0;
      sb.delete();
      #1;
      chk("abort_vld", dout_vld, 0);
      chk("abort_rdy", din_rdy, 1);
      chk("abort_q", dout_q, 0);
      chk("abort_r", dout_r, 0);
      chk("abort_err", dout_err, 0);
      @(negedge clk);
      chk("abort_vld_hold", dout_vld, 0);
      rstn = 1'b1;
      run_op(vecs[4]);
      run_op(vecs[5]);

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("final_drain", sb.size(), 0);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
